// File: rtl/data_mem_stage.sv
// LEGv8 data-memory stage: LDUR/STUR/LDURB/STURB behind a request/ready/done handshake
// with fixed access latency; misaligned, out-of-range and read+write requests fault.
module data_mem_stage #(
    parameter int unsigned DEPTH_DW = 256,
    parameter int unsigned LATENCY  = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteOp,
    output logic        Ready,
    output logic        Done,
    output logic        Fault,
    output logic [63:0] ReadData
);

    localparam int unsigned IdxW  = $clog2(DEPTH_DW);
    localparam int unsigned AddrW = IdxW + 3;
    localparam logic [63:0] AddrLimit = 64'(DEPTH_DW) << 3;
    // Done is the cycle that ends at edge accept+LATENCY, so BUSY lasts LATENCY-1 cycles.
    localparam int unsigned CntW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} stateE;

    stateE             stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [AddrW-1:0]  addrQ, addrD;
    logic [63:0]       dataQ, dataD;
    logic              byteOpQ, byteOpD;
    logic              writeQ, writeD;
    logic              faultQ, faultD;
    logic [63:0]       readDataQ, readDataD;

    logic [63:0]       mem [DEPTH_DW];

    logic              reqValid;
    logic              reqFault;
    logic              inBusy;
    logic [AddrW-1:0]  opAddr;
    logic [63:0]       opData;
    logic              opByte;
    logic              opWrite;
    logic [IdxW-1:0]   opIdx;
    logic [5:0]        laneSel;
    logic [63:0]       curWord;
    logic [63:0]       mergedWord;
    logic [63:0]       wrWord;
    logic [63:0]       ldWord;
    logic              doAccess;
    logic              memWe;

    assign reqValid = MemRead | MemWrite;
    assign reqFault = (MemRead & MemWrite) | (~ByteOp & (|Address[2:0])) |
                      (Address >= AddrLimit);

    // A single-cycle build completes on the accept edge, so operands come from the live inputs.
    assign inBusy  = (stateQ == StBusy);
    assign opAddr  = inBusy ? addrQ   : Address[AddrW-1:0];
    assign opData  = inBusy ? dataQ   : WriteData;
    assign opByte  = inBusy ? byteOpQ : ByteOp;
    assign opWrite = inBusy ? writeQ  : MemWrite;
    assign opIdx   = opAddr[AddrW-1:3];
    assign laneSel = {opAddr[2:0], 3'b000};
    assign curWord = mem[opIdx];

    always_comb begin
        mergedWord = curWord;
        mergedWord[laneSel +: 8] = opData[7:0];
    end

    assign wrWord = opByte ? mergedWord : opData;
    assign ldWord = opByte ? {56'd0, curWord[laneSel +: 8]} : curWord;

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        addrD     = addrQ;
        dataD     = dataQ;
        byteOpD   = byteOpQ;
        writeD    = writeQ;
        faultD    = faultQ;
        readDataD = readDataQ;
        doAccess  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                faultD = 1'b0;
                if (reqValid) begin
                    addrD   = Address[AddrW-1:0];
                    dataD   = WriteData;
                    byteOpD = ByteOp;
                    writeD  = MemWrite;
                    if (reqFault) begin
                        faultD = 1'b1;
                        stateD = StDone;
                    end else if (LATENCY == 1) begin
                        doAccess = 1'b1;
                        stateD   = StDone;
                    end else begin
                        cntD   = CntLoad;
                        stateD = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cntQ != '0) begin
                    cntD = cntQ - CntW'(1);
                end else begin
                    doAccess = 1'b1;
                    stateD   = StDone;
                end
            end
            StDone: begin
                faultD = 1'b0;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
        if (doAccess && !opWrite) begin
            readDataD = ldWord;
        end
    end

    // Reset wins over a completion on the same edge.
    assign memWe = doAccess & opWrite & ~Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ    <= StIdle;
            cntQ      <= '0;
            addrQ     <= '0;
            dataQ     <= '0;
            byteOpQ   <= 1'b0;
            writeQ    <= 1'b0;
            faultQ    <= 1'b0;
            readDataQ <= '0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            addrQ     <= addrD;
            dataQ     <= dataD;
            byteOpQ   <= byteOpD;
            writeQ    <= writeD;
            faultQ    <= faultD;
            readDataQ <= readDataD;
        end
    end

    always_ff @(posedge Clk) begin
        if (memWe) begin
            mem[opIdx] <= wrWord;
        end
    end

    assign Ready    = (stateQ == StIdle);
    assign Done     = (stateQ == StDone);
    assign Fault    = faultQ;
    assign ReadData = readDataQ;

endmodule

// File: tb/tb_data_mem_stage.sv
// Directed bench for data_mem_stage: vector table plus reset, held-request and
// single-cycle-latency sequences.
module tb_data_mem_stage;

    logic        clk;
    logic        reset;
    logic [63:0] address, writeData;
    logic        memRead, memWrite, byteOp;
    logic        ready, done, fault;
    logic [63:0] readData;

    logic [63:0] address1, writeData1;
    logic        memRead1, memWrite1, byteOp1;
    logic        ready1, done1, fault1;
    logic [63:0] readData1;

    int total = 0;
    int bad   = 0;

    data_mem_stage #(.DEPTH_DW(256), .LATENCY(2)) dut (
        .Clk(clk), .Reset(reset), .Address(address), .WriteData(writeData),
        .MemRead(memRead), .MemWrite(memWrite), .ByteOp(byteOp),
        .Ready(ready), .Done(done), .Fault(fault), .ReadData(readData)
    );

    data_mem_stage #(.DEPTH_DW(256), .LATENCY(1)) dut1 (
        .Clk(clk), .Reset(reset), .Address(address1), .WriteData(writeData1),
        .MemRead(memRead1), .MemWrite(memWrite1), .ByteOp(byteOp1),
        .Ready(ready1), .Done(done1), .Fault(fault1), .ReadData(readData1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        bop;
        logic [63:0] addr;
        logic [63:0] wd;
        logic        expFault;
        logic [63:0] expRd;
    } vecT;

    vecT tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where Done is seen.
    task automatic acc(input logic rd, input logic wr, input logic bop, input logic [63:0] addr,
                       input logic [63:0] wd, output int lat, output logic flt,
                       output logic [63:0] rdat);
        int w = 0;
        @(negedge clk);
        while (!ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!ready) chk("ready_wait", 64'(ready), 64'd1);
        memRead = rd; memWrite = wr; byteOp = bop; address = addr; writeData = wd;
        @(posedge clk);
        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        flt  = fault;
        rdat = readData;
    endtask

    task automatic acc1(input logic rd, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wd, output int lat, output logic flt,
                        output logic [63:0] rdat);
        int w = 0;
        @(negedge clk);
        while (!ready1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!ready1) chk("ready1_wait", 64'(ready1), 64'd1);
        memRead1 = rd; memWrite1 = wr; byteOp1 = 1'b0; address1 = addr; writeData1 = wd;
        @(posedge clk);
        @(negedge clk);
        memRead1 = 1'b0; memWrite1 = 1'b0;
        lat = 1;
        while (!done1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done1) lat = -1;
        flt  = fault1;
        rdat = readData1;
    endtask

    task automatic runVec(input int i);
        int          lat;
        logic        flt;
        logic [63:0] rdat;
        acc(tbl[i].rd, tbl[i].wr, tbl[i].bop, tbl[i].addr, tbl[i].wd, lat, flt, rdat);
        chk($sformatf("v%0d_latency", i), 64'(lat), tbl[i].expFault ? 64'd1 : 64'd2);
        chk($sformatf("v%0d_fault", i), 64'(flt), 64'(tbl[i].expFault));
        chk($sformatf("v%0d_readdata", i), rdat, tbl[i].expRd);
    endtask

    initial begin
        int          lat;
        logic        flt;
        logic [63:0] rdat;

        //          rd    wr    bop   addr                    wd                      flt   readData
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 64'h10,               64'h5555,               1'b0, 64'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 64'h10,               64'h0,                  1'b0, 64'h5555};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 64'h18,               64'h0123456789ABCDEF,   1'b0, 64'h5555};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 64'h18,               64'h0,                  1'b0,
                    64'h0123456789ABCDEF};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 64'h20,               64'h1111111111111111,   1'b0,
                    64'h0123456789ABCDEF};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 64'h23,               64'hFFFFFFFFFFFFFFAB,   1'b0,
                    64'h0123456789ABCDEF};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 64'h20,               64'h0,                  1'b0,
                    64'h11111111AB111111};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 64'h23,               64'h0,                  1'b0, 64'hAB};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 64'h0,                64'h77,                 1'b0, 64'hAB};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 64'h0C,               64'h0,                  1'b1, 64'hAB};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 64'h800,              64'hBAD,                1'b1, 64'hAB};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 64'h0,                64'hBAD,                1'b1, 64'hAB};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 64'h1000000000000010, 64'hBAD,                1'b1, 64'hAB};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 64'h0,                64'h0,                  1'b0, 64'h77};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 64'h10,               64'h0,                  1'b0, 64'h5555};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 64'h7FF,              64'hCD,                 1'b0, 64'h5555};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 64'h7FF,              64'h0,                  1'b0, 64'hCD};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 64'h800,              64'h0,                  1'b1, 64'hCD};
        tbl[18] = '{1'b1, 1'b0, 1'b1, 64'h21,               64'h0,                  1'b0, 64'h11};

        reset = 1'b1;
        memRead = 0; memWrite = 0; byteOp = 0; address = 0; writeData = 0;
        memRead1 = 0; memWrite1 = 0; byteOp1 = 0; address1 = 0; writeData1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_readdata", readData, 64'd0);

        runVec(0);
        runVec(1);

        // Reset lands on the completion edge of a store of 0xDEAD to 0x10.
        @(negedge clk);
        memWrite = 1'b1; address = 64'h10; writeData = 64'hDEAD; byteOp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        memWrite = 1'b0;
        chk("busy_ready", 64'(ready), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", 64'(ready), 64'd1);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_readdata", readData, 64'd0);
        acc(1'b1, 1'b0, 1'b0, 64'h10, 64'h0, lat, flt, rdat);
        chk("midrst_reload", rdat, 64'h5555);

        for (int i = 2; i < 19; i++) runVec(i);

        // Held load: accepts every 3 cycles, never while not ready.
        @(negedge clk);
        memRead = 1'b1; address = 64'h18; byteOp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("held_ready_%0d", i), 64'(ready), 64'((i % 3) == 0));
            chk($sformatf("held_done_%0d", i), 64'(done), 64'((i % 3) == 2));
            if (i == 8) memRead = 1'b0;
            @(negedge clk);
        end
        chk("held_readdata", readData, 64'h0123456789ABCDEF);

        acc1(1'b0, 1'b1, 64'h18, 64'h0123456789ABCDEF, lat, flt, rdat);
        chk("lat1_st_latency", 64'(lat), 64'd1);
        chk("lat1_st_fault", 64'(flt), 64'd0);
        acc1(1'b1, 1'b0, 64'h18, 64'h0, lat, flt, rdat);
        chk("lat1_ld_latency", 64'(lat), 64'd1);
        chk("lat1_ld_fault", 64'(flt), 64'd0);
        chk("lat1_ld_readdata", rdat, 64'h0123456789ABCDEF);
        acc1(1'b1, 1'b0, 64'h0C, 64'h0, lat, flt, rdat);
        chk("lat1_mis_latency", 64'(lat), 64'd1);
        chk("lat1_mis_fault", 64'(flt), 64'd1);
        chk("lat1_mis_readdata", rdat, 64'h0123456789ABCDEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
